// File: rtl/pipe_stage_bank.sv
// Bank of STAGES pipeline latches with per-stage stall and flush.
// Empty slots collapse under backpressure, and bubbles caused by stalls are counted.
module pipe_stage_bank #(
    parameter int unsigned      WIDTH  = 32,
    parameter int unsigned      STAGES = 4,
    parameter logic [WIDTH-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic [STAGES-1:0] stall,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [STAGES-1:0] stage_valid,
    output logic [15:0]       bubble_count
);

    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d        [STAGES];
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] feedValid;
    logic [WIDTH-1:0]  feedData [STAGES];
    logic [STAGES-1:0] bubbleHit;
    logic              downHold;
    logic              killAcc;
    logic              inAccept;

    // Hold propagates from the output end; flush kills the named stage and every younger one.
    always_comb begin
        hold     = '0;
        kill     = '0;
        downHold = ~out_ready;
        killAcc  = 1'b0;
        for (int i = int'(LAST); i >= 0; i--) begin
            hold[i]  = stall[i] | (v[i] & downHold);
            downHold = hold[i];
            killAcc  = killAcc | flush[i];
            kill[i]  = killAcc;
        end
    end

    assign in_ready    = ~hold[0] & ~(|flush);
    assign inAccept    = in_valid & in_ready;
    assign out_valid   = v[LAST] & ~stall[LAST];
    assign out_data    = d[LAST];
    assign stage_valid = v;

    // What each stage would load if it moves; bubbleHit marks a slot starved by a held, valid predecessor.
    always_comb begin
        feedValid = '0;
        bubbleHit = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            feedData[i] = NOP;
        end
        feedValid[0] = inAccept;
        feedData[0]  = in_data;
        for (int i = 1; i < int'(STAGES); i++) begin
            feedValid[i] = v[i-1] & ~kill[i-1] & ~hold[i-1];
            feedData[i]  = d[i-1];
            bubbleHit[i] = ~kill[i] & ~hold[i] & v[i-1] & hold[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v            <= '0;
            bubble_count <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                d[i] <= NOP;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (kill[i]) begin
                    v[i] <= 1'b0;
                    d[i] <= NOP;
                end else if (!hold[i]) begin
                    v[i] <= feedValid[i];
                    d[i] <= feedValid[i] ? feedData[i] : NOP;
                end
            end
            if ((|bubbleHit) && (bubble_count != 16'hFFFF)) begin
                bubble_count <= bubble_count + 16'(1);
            end
        end
    end

endmodule
